// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path:
// FSM states, decoded opcodes and the ALU operand/operation selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_HALT     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  // An instruction retires on the edge that leaves its last step; a store
  // only leaves MEM_WR once memory acknowledges it.
  function automatic logic is_retire(input logic [3:0] st, input logic mem_ready);
    return (st == ST_MEM_WB) || (st == ST_ALU_WB) || (st == ST_BRANCH) ||
           ((st == ST_MEM_WR) && mem_ready);
  endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Combinational strobe/select decode for the multi-cycle control FSM.
// Moore outputs per state, plus the FETCH/BRANCH PC writes and IR load
// that depend on mem_ready and the ALU zero flag.
module mc_output_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       PCSource,
  output logic       illegal
);

  // Per-state output decode; undefined encodings leave everything low.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REGB;
    ALUop    = ALU_ADD;
    PCSource = 1'b0;
    illegal  = 1'b0;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM_SH1;
      end
      ST_MEM_ADDR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC_R: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        ALUop   = ALU_RTYPE;
      end
      ST_EXEC_I: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALU_ITYPE;
      end
      ST_ALU_WB: begin
        RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = SRCA_REGA;
        ALUSrcB  = SRCB_REGB;
        ALUop    = ALU_SUB;
        PCSource = 1'b1;
        PCWrite  = zero;
      end
      ST_HALT: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle RV32I-subset core: state register,
// opcode-driven sequencing, retired-instruction counter, and reset gating
// of the write/memory strobes.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUop,
  output logic        PCSource,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       retire;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  mc_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .PCWrite   (pc_write_raw),
    .IRWrite   (ir_write_raw),
    .IorD      (IorD),
    .MemRead   (mem_read_raw),
    .MemWrite  (mem_write_raw),
    .MemtoReg  (MemtoReg),
    .RegWrite  (reg_write_raw),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUop     (ALUop),
    .PCSource  (PCSource),
    .illegal   (illegal)
  );

  // A cycle under reset must not touch PC, IR, memory or the register file.
  assign PCWrite  = pc_write_raw  & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign MemRead  = mem_read_raw  & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;

  assign retire = is_retire(state_q, mem_ready);
  assign state  = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter; reset beats a coincident retire.
  always_ff @(posedge clk) begin
    if (reset) instret <= 32'd0;
    else       instret <= instret + {31'd0, retire};
  end

  // Next-state sequencing; memory steps hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
          OP_RTYPE:          state_d = ST_EXEC_R;
          OP_ITYPE:          state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = ST_BRANCH;
          default:           state_d = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_EXEC_R:   state_d = ST_ALU_WB;
      ST_EXEC_I:   state_d = ST_ALU_WB;
      ST_ALU_WB:   state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed reset/illegal/mid-store/wrap steps
// plus a run of random instructions with random memory wait states, each
// expanded into its expected per-cycle step list.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUop;
  logic        PCSource, illegal;
  logic [31:0] instret;
  logic [3:0]  state;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4,
                 MEM_WR = 5, EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9,
                 HALT = 10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BEQ = 7'b1100011, BAD = 7'b1111111;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUop, PCSource, illegal};
  logic [4:0] strobes;
  assign strobes = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};

  // Output table written straight from the step descriptions:
  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,SrcA,SrcB,ALUop,PCSource,illegal}
  function automatic logic [14:0] expect_outs(input int st, input logic mr, input logic z);
    case (st)
      FETCH:    return {mr, mr, 1'b0, 1'b1, 3'b000, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
      DECODE:   return {7'b0000000, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0};
      MEM_ADDR: return {7'b0000000, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
      MEM_RD:   return {7'b0011000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      MEM_WB:   return {7'b0000011, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      MEM_WR:   return {7'b0010100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      EXEC_R:   return {7'b0000000, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
      EXEC_I:   return {7'b0000000, 2'b10, 2'b10, 2'b11, 1'b0, 1'b0};
      ALU_WB:   return {7'b0000001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      BRANCH:   return {z, 6'b000000, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
      default:  return {7'b0000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle in which the DUT is expected to sit in state st.
  task automatic step(input int st, input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
    chk($sformatf("state_exp%0d", st), {28'd0, state}, st);
    chk($sformatf("outs_st%0d_mr%0b", st, mr), {17'd0, outs}, {17'd0, expect_outs(st, mr, zero)});
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle sequence and check the retire.
  task automatic run_instr(input logic [6:0] op, input logic z,
                           input int fstall, input int mstall);
    opcode = op;
    zero   = z;
    for (int i = 0; i < fstall; i++) step(FETCH, 1'b0);
    step(FETCH, 1'b1);
    step(DECODE, rbit());
    case (op)
      LW: begin
        step(MEM_ADDR, rbit());
        for (int i = 0; i < mstall; i++) step(MEM_RD, 1'b0);
        step(MEM_RD, 1'b1);
        step(MEM_WB, rbit());
      end
      SW: begin
        step(MEM_ADDR, rbit());
        for (int i = 0; i < mstall; i++) step(MEM_WR, 1'b0);
        step(MEM_WR, 1'b1);
      end
      RT: begin
        step(EXEC_R, rbit());
        step(ALU_WB, rbit());
      end
      IT: begin
        step(EXEC_I, rbit());
        step(ALU_WB, rbit());
      end
      BEQ: step(BRANCH, rbit());
      default: begin
        for (int i = 0; i < 20; i++) begin
          opcode = 7'($urandom);
          step(HALT, rbit());
        end
        return;
      end
    endcase
    exp_instret = exp_instret + 32'd1;
    @(posedge clk);
    #1;
    chk("instret_after_retire", instret, exp_instret);
  endtask

  // Assert reset for one cycle from the current negedge, then release it
  // just after the edge that samples it.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk({tag, "_strobes_in_reset"}, {27'd0, strobes}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_instret = 32'd0;
    chk({tag, "_state_after_reset"}, {28'd0, state}, FETCH);
    chk({tag, "_instret_after_reset"}, instret, exp_instret);
    chk({tag, "_illegal_after_reset"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    logic [6:0] ops [5];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BEQ;
    reset       = 1'b1;
    mem_ready   = 1'b1;
    opcode      = RT;
    zero        = 1'b0;
    exp_instret = 32'd0;

    // Power-up reset: two cycles high, strobes quiet throughout.
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("strobes_in_initial_reset", {27'd0, strobes}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("state_after_initial_reset", {28'd0, state}, FETCH);
    chk("instret_after_initial_reset", instret, 32'd0);
    chk("illegal_after_initial_reset", {31'd0, illegal}, 32'd0);

    // R-type with no waits: FETCH, DECODE, EXEC_R, ALU_WB.
    run_instr(RT, 1'b0, 0, 0);
    // lw with three wait states in MEM_RD.
    run_instr(LW, 1'b0, 0, 3);
    // beq taken and not taken.
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);

    // Random instruction mix with random wait states.
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], rbit(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Illegal opcode halts until reset.
    run_instr(BAD, 1'b0, 1, 0);
    pulse_reset("illegal");

    // Retire something, then abandon a stalled store with reset.
    run_instr(IT, 1'b0, 0, 0);
    opcode = SW;
    step(FETCH, 1'b1);
    step(DECODE, 1'b0);
    step(MEM_ADDR, 1'b0);
    step(MEM_WR, 1'b0);
    step(MEM_WR, 1'b0);
    pulse_reset("mid_store");

    // Counter wrap: preload all ones during a stalled fetch, then one sw.
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret;
    #1;
    exp_instret = 32'hFFFF_FFFF;
    chk("instret_preload", instret, exp_instret);
    chk("state_stalled_fetch", {28'd0, state}, FETCH);
    run_instr(SW, 1'b0, 0, 0);
    chk("instret_wrapped_to_zero", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control FSM for the multi-cycle RV32I-subset processor: sequences one shared memory port, one ALU and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps instead of the single-cycle datapath's dedicated adders and split memories. It decodes the latched instruction opcode and drives every datapath enable and mux select. Memory accesses stall on a ready handshake. It also counts retired instructions.

## Interface
- No parameters. Encodings come from `multicycle_pkg`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `PCWrite` out 1: PC load enable, already combined as unconditional OR (branch & `zero`).
- `IRWrite` out 1: load IR and OldPC.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `MemtoReg` out 1: writeback select; 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1: register-file write.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = regA.
- `ALUSrcB` out 2: 00 = regB, 01 = const 4, 10 = Imm, 11 = Imm<<1.
- `ALUop` out 2: 00 = add, 01 = sub, 10 = R-type funct, 11 = I-type funct3 only.
- `PCSource` out 1: 0 = ALU result, 1 = ALUOut.
- `illegal` out 1: core halted on an unsupported opcode.
- `instret` out 32: retired-instruction count.
- `state` out 4: current state, for debug.

## Operation
- Outputs are Moore decodes of `state`, except `IRWrite`, FETCH's `PCWrite`, and BRANCH's `PCWrite`. Any output not listed for a state is 0.
- **FETCH (0)**
  - Drives `MemRead=1`, `IorD=0`, `ALUSrcA=00`, `ALUSrcB=01`, `ALUop=00`, `PCSource=0`.
  - `IRWrite` and `PCWrite` = `mem_ready`.
  - Goes to DECODE on `mem_ready`, otherwise holds.
- **DECODE (1)**
  - Drives `ALUSrcA=01`, `ALUSrcB=11`, `ALUop=00`, which places the branch target in ALUOut.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEM_ADDR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH.
    - Any other opcode → HALT.
- **MEM_ADDR (2)**: `ALUSrcA=10`, `ALUSrcB=10`, `ALUop=00`. Goes to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD (3)**: `MemRead=1`, `IorD=1`. Goes to MEM_WB on `mem_ready`, otherwise holds.
- **MEM_WB (4)**: `RegWrite=1`, `MemtoReg=1`. Goes to FETCH and retires the instruction.
- **MEM_WR (5)**: `MemWrite=1`, `IorD=1`. On `mem_ready`, goes to FETCH and retires the instruction.
- **EXEC_R (6)**: `ALUSrcA=10`, `ALUSrcB=00`, `ALUop=10`. Goes to ALU_WB.
- **EXEC_I (7)**: `ALUSrcA=10`, `ALUSrcB=10`, `ALUop=11`. Goes to ALU_WB.
- **ALU_WB (8)**: `RegWrite=1`, `MemtoReg=0`. Goes to FETCH and retires the instruction.
- **BRANCH (9)**
  - Drives `ALUSrcA=10`, `ALUSrcB=00`, `ALUop=01`, `PCSource=1`.
  - `PCWrite` = `zero`.
  - Goes to FETCH and retires the instruction whether or not the branch is taken.
- **HALT (10)**: all strobes 0, `illegal=1`. Holds until `reset`.
- Undefined encodings 11–15 go to HALT.
- `instret` increments by 1 on every retire edge and wraps from 0xFFFFFFFF to 0.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR is stable there.

## Timing
- **Reset**
  - While `reset`=1, every strobe output is forced to 0.
  - At the next edge: `state`=FETCH, `instret`=0, `illegal`=0.
- **Reset mid-operation** (for example a stalled MEM_WR): the access is abandoned. No retire is counted, and no `RegWrite`/`PCWrite` occurs in the reset cycle.
- **Cycles per instruction**, with `mem_ready` held high: beq 3, R/I-ALU 4, sw 4, lw 5.
- Each cycle of `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `MemRead`/`MemWrite` stay asserted continuously until the `mem_ready` cycle. They are never pulsed.
- A `mem_ready` seen outside FETCH, MEM_RD or MEM_WR is ignored.
- Retire and reset on the same edge: reset wins and `instret`=0.

## Structure
- **`multicycle_pkg`** holds:
  - the state enumeration (4-bit, values above);
  - opcode constants (`OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`);
  - the `ALUSrcA`, `ALUSrcB` and `ALUop` encodings.
- **`mc_output_decode`**: one combinational sub-module mapping (`state`, `mem_ready`, `zero`) to the strobes.
- **Top level** keeps the state register, next-state logic and the `instret` counter.

## Test plan
- **Reset**: reset high for 2 cycles, then low, with `mem_ready`=1 and opcode 0110011.
  - States: FETCH→DECODE→EXEC_R→ALU_WB→FETCH.
  - `RegWrite`=1 only in cycle 4; `instret`=1 after cycle 4.
- **lw with wait state**: opcode 0000011, `mem_ready` low for 3 cycles in MEM_RD.
  - `MemRead`/`IorD` held for 4 cycles; MEM_WB follows.
  - Total 8 cycles; `instret` +1.
- **beq**: opcode 1100011.
  - With `zero`=1: `PCWrite`=1, `PCSource`=1 in BRANCH.
  - With `zero`=0: `PCWrite`=0.
  - Both cases take 3 cycles and retire.
- **Illegal opcode**: 1111111 in DECODE.
  - HALT next cycle, `illegal`=1, all strobes 0 for 20 cycles.
  - Reset returns to FETCH with `illegal`=0.
- **Reset mid-store**: assert reset during a stalled MEM_WR.
  - `MemWrite` drops in the reset cycle; next state is FETCH; `instret`=0.
- **Counter wrap**: force `instret` to 0xFFFFFFFF, then run one sw.
  - `instret` reads 0.
